gfx_fetch_arbiter: RTL and testbench
====================================

Name: gfx_fetch_arbiter

Overview:
- Shares the single external graphics ROM port (gfx_read / gfx_addr / gfx_data) between two fetch requesters.
- Requester 0 is the background tile fetcher; requester 1 is the sprite pixel fetcher.
- Sits between the video fetch engines and the SDRAM/ROM bridge in the top-level game module.
- Serialises one byte read at a time, selects priority (fixed or round-robin), and routes returned data and an acknowledge pulse back to the owning requester.

Parameters:
- ADDR_W, 19, graphics ROM byte-address width.
- TIMEOUT, 64, cycles spent in WAIT before a forced completion (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- bg_req  in  1  background fetch request; held high until bg_ack.
- bg_addr  in  ADDR_W  background byte address; stable while bg_req is high.
- bg_ack  out  1  one-cycle pulse; bg_data is valid in that cycle.
- bg_data  out  8  background read data.
- sp_req  in  1  sprite fetch request; held high until sp_ack.
- sp_addr  in  ADDR_W  sprite byte address.
- sp_ack  out  1  one-cycle pulse; sp_data is valid in that cycle.
- sp_data  out  8  sprite read data.
- prio_bg  in  1  1 = fixed background priority; 0 = round-robin.
- gfx_read  out  1  one-cycle read strobe to the ROM bridge.
- gfx_addr  out  ADDR_W  ROM address; held from strobe until completion.
- gfx_data  in  8  ROM read data.
- gfx_valid  in  1  ROM data-valid pulse; arrives at least 1 cycle after gfx_read.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - State IDLE; last_grant = SP, so the background wins the first tie.
  - gfx_read=0, gfx_addr=0, bg_ack=0, sp_ack=0, bg_data=0, sp_data=0, busy=0.
- All outputs are registered.
- State machine IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Only one request high: grant it.
  - Both high and prio_bg=1: grant BG.
  - Both high and prio_bg=0: grant the requester that is not last_grant.
  - On a grant: latch owner, load gfx_addr from the owner's address, update last_grant, go to ISSUE.
- ISSUE: gfx_read=1 for exactly this cycle; go to WAIT.
- WAIT:
  - gfx_valid=1: capture gfx_data into the owner's data register, go to DONE.
  - gfx_valid is ignored in every other state.
- DONE:
  - The owner's ack is high for exactly this cycle; its data register holds the value just captured.
  - Next state is IDLE.
- Requester rule: register req low on the edge that ends the ack cycle. The following IDLE cycle therefore sees that req low, with no accidental re-grant.
- Throughput: minimum 4 cycles per access, i.e. IDLE + ISSUE + WAIT(>=1) + DONE.
  - With gfx_valid 1 cycle after gfx_read: req at edge N -> gfx_read at cycle N+1 -> ack at cycle N+3.
- Data registers:
  - bg_data and sp_data hold their value until the next completion for that same requester.
  - A completion for the other requester does not disturb them.
- Request dropped mid-transaction: the transaction still completes and the ack is still issued; the requester ignores it. No abort path.
- Requests and prio_bg are sampled only in IDLE.
  - An addr change while granted has no effect on gfx_addr.
  - A prio_bg change mid-transaction applies to the next arbitration.
- Round-robin, both requests held continuously with prio_bg=0: grants strictly alternate BG, SP, BG, SP...
- Fixed priority, both held with prio_bg=1: SP is starved while bg_req stays high. This is intended; the background fetch is line-critical.
- Reset in any state:
  - Returns to IDLE next edge; all strobes and acks go low.
  - A late gfx_valid after reset is ignored.
  - No ack is issued for the interrupted transaction.
- gfx_valid with gfx_read in the same cycle is out of contract; behaviour is undefined.

Optional Feature:
- Macro: GFX_FETCH_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT-1 without gfx_valid, the owner's data register is loaded with 8'hFF and the block goes to DONE (ack issued normally).
  - A sticky output timeout_flag (1 bit, reset 0) is set and stays set until reset.
- Not defined: no counter, no timeout_flag port; WAIT persists indefinitely until gfx_valid.

Test Plan:
- Single BG read: bg_req=1, bg_addr=19'h12345; model returns 8'hA5 one cycle after gfx_read -> gfx_read one pulse with gfx_addr=19'h12345; bg_ack one pulse 2 cycles later with bg_data=8'hA5; sp_ack stays 0.
- Tie, round-robin: prio_bg=0, both reqs high from reset, BG addr 19'h00010, SP addr 19'h40020, each requester re-raises after its ack -> gfx_addr sequence 00010, 40020, 00010, 40020; acks alternate.
- Tie, fixed priority: prio_bg=1, both held for 8 BG accesses -> zero SP grants; after bg_req drops, SP is granted on the next IDLE.
- Variable latency: gfx_valid delayed 1, 5, then 17 cycles -> busy stays high throughout; a single gfx_read per access; ack only after gfx_valid; data intact.
- Reset in WAIT: reset asserted while waiting, then gfx_valid arrives 2 cycles later -> no ack; busy=0; gfx_read=0; next request serviced normally with last_grant=SP.
- Timeout (macro defined, TIMEOUT=64): gfx_valid never returned for an SP request -> sp_ack at 64 WAIT cycles with sp_data=8'hFF; timeout_flag=1 and remains 1.

Source files
------------

// File: rtl/gfx_fetch_arbiter_if.sv
// gfx_fetch_arbiter_if: requester and graphics-ROM signals of the fetch arbiter.
// The master side is the environment (video fetchers plus ROM bridge); the
// slave side is the arbiter itself. timeout_flag exists only when
// GFX_FETCH_ARBITER_TIMEOUT_EN is defined.
interface gfx_fetch_arbiter_if #(
    parameter int ADDR_W = 19
);
    // Background tile fetcher (requester 0)
    logic              bg_req;
    logic [ADDR_W-1:0] bg_addr;
    logic              bg_ack;
    logic [7:0]        bg_data;
    // Sprite pixel fetcher (requester 1)
    logic              sp_req;
    logic [ADDR_W-1:0] sp_addr;
    logic              sp_ack;
    logic [7:0]        sp_data;
    // Arbitration mode and status
    logic              prio_bg;
    logic              busy;
    // Shared graphics ROM port
    logic              gfx_read;
    logic [ADDR_W-1:0] gfx_addr;
    logic [7:0]        gfx_data;
    logic              gfx_valid;
`ifdef GFX_FETCH_ARBITER_TIMEOUT_EN
    logic              timeout_flag;
`endif

    modport master (
        output bg_req, bg_addr, sp_req, sp_addr, prio_bg, gfx_data, gfx_valid,
        input  bg_ack, bg_data, sp_ack, sp_data, gfx_read, gfx_addr, busy
`ifdef GFX_FETCH_ARBITER_TIMEOUT_EN
        , input timeout_flag
`endif
    );

    modport slave (
        input  bg_req, bg_addr, sp_req, sp_addr, prio_bg, gfx_data, gfx_valid,
        output bg_ack, bg_data, sp_ack, sp_data, gfx_read, gfx_addr, busy
`ifdef GFX_FETCH_ARBITER_TIMEOUT_EN
        , output timeout_flag
`endif
    );
endinterface

// File: rtl/gfx_fetch_arbiter.sv
// gfx_fetch_arbiter: shares the single graphics ROM byte port between the
// background tile fetcher and the sprite pixel fetcher. One read is in flight
// at a time (IDLE -> ISSUE -> WAIT -> DONE); priority is fixed-background or
// round-robin via prio_bg. All outputs are registered.
// Optional build macro GFX_FETCH_ARBITER_TIMEOUT_EN: WAIT gives up after
// TIMEOUT cycles, returns 8'hFF to the owner and sets a sticky timeout_flag.
module gfx_fetch_arbiter #(
    parameter int ADDR_W  = 19
`ifdef GFX_FETCH_ARBITER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input logic                clk_sys,
    input logic                reset,
    gfx_fetch_arbiter_if.slave bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
    typedef enum logic {REQ_BG = 1'b0, REQ_SP = 1'b1} req_t;

    state_t            state;
    req_t              owner;
    req_t              last_grant;

    logic              grant_valid;
    req_t              grant_sel;
    logic [ADDR_W-1:0] grant_addr;
    logic              wait_done;
    logic [7:0]        wait_data;

`ifdef GFX_FETCH_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  wait_cnt;
    logic              timeout_hit;
`endif

    // Arbitration winner for an IDLE cycle and the completion condition for WAIT.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and infers a latch.
        grant_valid = bus.bg_req | bus.sp_req;
        grant_sel   = REQ_BG;
        if (bus.bg_req && bus.sp_req) begin
            // Tie: fixed mode always favours the background fetch; round-robin
            // hands the port to whichever requester did not win last time.
            if (!bus.prio_bg && last_grant == REQ_BG) begin
                grant_sel = REQ_SP;
            end
        end else if (bus.sp_req) begin
            grant_sel = REQ_SP;
        end
        grant_addr = (grant_sel == REQ_SP) ? bus.sp_addr : bus.bg_addr;

        wait_done = bus.gfx_valid;
        wait_data = bus.gfx_data;
`ifdef GFX_FETCH_ARBITER_TIMEOUT_EN
        timeout_hit = !bus.gfx_valid && (wait_cnt == CNT_W'(TIMEOUT - 1));
        if (timeout_hit) begin
            wait_done = 1'b1;
            wait_data = 8'hFF;
        end
`endif
    end

    // Access sequencer: grant, strobe the ROM once, wait for data, acknowledge the owner.
    always_ff @(posedge clk_sys) begin
        // NOTE: registers use non-blocking assignments so each one samples the values from before the edge.
        if (reset) begin
            state        <= ST_IDLE;
            owner        <= REQ_BG;
            last_grant   <= REQ_SP;
            bus.gfx_read <= 1'b0;
            bus.gfx_addr <= '0;
            bus.bg_ack   <= 1'b0;
            bus.sp_ack   <= 1'b0;
            bus.bg_data  <= 8'h00;
            bus.sp_data  <= 8'h00;
            bus.busy     <= 1'b0;
`ifdef GFX_FETCH_ARBITER_TIMEOUT_EN
            wait_cnt         <= '0;
            bus.timeout_flag <= 1'b0;
`endif
        end else begin
            // Strobe and acks are single-cycle pulses unless a state raises them.
            bus.gfx_read <= 1'b0;
            bus.bg_ack   <= 1'b0;
            bus.sp_ack   <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner        <= grant_sel;
                        last_grant   <= grant_sel;
                        bus.gfx_addr <= grant_addr;
                        bus.gfx_read <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef GFX_FETCH_ARBITER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        if (owner == REQ_SP) begin
                            bus.sp_data <= wait_data;
                            bus.sp_ack  <= 1'b1;
                        end else begin
                            bus.bg_data <= wait_data;
                            bus.bg_ack  <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
`ifdef GFX_FETCH_ARBITER_TIMEOUT_EN
                    wait_cnt <= wait_cnt + 1'b1;
                    if (timeout_hit) begin
                        bus.timeout_flag <= 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_fetch_arbiter.sv
// tb_gfx_fetch_arbiter: directed bench for gfx_fetch_arbiter. A negedge
// process models the ROM bridge (configurable latency, byte = addr[7:0]^8'hE0)
// and records strobes and acks; one initial block walks the directed steps.
// The timeout step is compiled only with GFX_FETCH_ARBITER_TIMEOUT_EN.
module tb_gfx_fetch_arbiter;
    localparam int AW = 19;

    logic clk_sys = 1'b0;
    logic reset;

    gfx_fetch_arbiter_if #(.ADDR_W(AW)) bus ();

    gfx_fetch_arbiter #(.ADDR_W(AW)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    initial forever #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    // ROM model controls (written by the stimulus only)
    int rom_lat  = 1;
    bit rom_mute = 1'b0;

    // Observations (written by the monitor only)
    int              reads   = 0;
    int              bg_acks = 0;
    int              sp_acks = 0;
    logic [AW-1:0]   rd_addr_q[$];
    bit              ack_q[$];

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hE0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Waits (bounded) for the selected ack, sampling at negedges.
    task automatic wait_ack(input bit sel_sp, input int budget, output int n, output int busy_gaps);
        bit seen;
        seen      = 1'b0;
        n         = 0;
        busy_gaps = 0;
        while (!seen && n < budget) begin
            @(negedge clk_sys);
            n++;
            seen = sel_sp ? (bus.sp_ack === 1'b1) : (bus.bg_ack === 1'b1);
            if (!seen && bus.busy !== 1'b1) busy_gaps++;
        end
        check(sel_sp ? "sp_ack_seen" : "bg_ack_seen", seen, 1);
    endtask

    // ROM bridge model and monitor.
    initial begin
        int            cd;
        bit            pend;
        logic [AW-1:0] pa;
        pend          = 1'b0;
        cd            = 0;
        pa            = '0;
        bus.gfx_valid = 1'b0;
        bus.gfx_data  = 8'h00;
        forever begin
            @(negedge clk_sys);
            bus.gfx_valid = 1'b0;
            if (bus.bg_ack === 1'b1) begin bg_acks++; ack_q.push_back(1'b0); end
            if (bus.sp_ack === 1'b1) begin sp_acks++; ack_q.push_back(1'b1); end
            if (pend) begin
                cd--;
                if (cd <= 0) begin
                    pend = 1'b0;
                    if (!rom_mute) begin
                        bus.gfx_valid = 1'b1;
                        bus.gfx_data  = rom_byte(pa);
                    end
                end
            end
            if (bus.gfx_read === 1'b1) begin
                reads++;
                rd_addr_q.push_back(bus.gfx_addr);
                pend = 1'b1;
                cd   = rom_lat;
                pa   = bus.gfx_addr;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        int            g;
        int            b_rd;
        int            b_bg;
        int            b_sp;
        int            b_q;
        int            lats[3];
        logic [AW-1:0] addrs[3];

        lats  = '{1, 5, 17};
        addrs = '{19'h00AB1, 19'h7FF3C, 19'h2345E};

        // ---- Reset state
        reset       = 1'b1;
        bus.bg_req  = 1'b0;
        bus.bg_addr = '0;
        bus.sp_req  = 1'b0;
        bus.sp_addr = '0;
        bus.prio_bg = 1'b1;
        repeat (3) step();
        check("rst_strobes", {bus.gfx_read, bus.bg_ack, bus.sp_ack, bus.busy}, 4'b0000);
        check("rst_gfx_addr", bus.gfx_addr, 0);
        check("rst_bg_data", bus.bg_data, 8'h00);
        check("rst_sp_data", bus.sp_data, 8'h00);
`ifdef GFX_FETCH_ARBITER_TIMEOUT_EN
        check("rst_timeout_flag", bus.timeout_flag, 0);
`endif
        reset = 1'b0;
        step();

        // ---- Single background read
        rom_lat     = 1;
        b_rd        = reads;
        b_bg        = bg_acks;
        b_sp        = sp_acks;
        bus.bg_req  = 1'b1;
        bus.bg_addr = 19'h12345;
        wait_ack(1'b0, 20, n, g);
        check("single_latency", n, 4);
        check("single_bg_data", bus.bg_data, 8'hA5);
        check("single_gfx_addr", bus.gfx_addr, 19'h12345);
        step();
        bus.bg_req = 1'b0;
        repeat (3) step();
        check("single_reads", reads - b_rd, 1);
        check("single_read_addr", rd_addr_q[b_rd], 19'h12345);
        check("single_bg_acks", bg_acks - b_bg, 1);
        check("single_sp_acks", sp_acks - b_sp, 0);
        check("single_busy_idle", bus.busy, 0);

        // ---- Round-robin tie, both requests high from reset
        reset       = 1'b1;
        bus.prio_bg = 1'b0;
        bus.bg_addr = 19'h00010;
        bus.sp_addr = 19'h40020;
        bus.bg_req  = 1'b1;
        bus.sp_req  = 1'b1;
        step();
        step();
        b_rd  = reads;
        b_q   = ack_q.size();
        reset = 1'b0;
        n     = 0;
        while (ack_q.size() < b_q + 4 && n < 60) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        check("rr_four_acks", ack_q.size() >= b_q + 4, 1);
        step();
        bus.bg_req = 1'b0;
        bus.sp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rr_gfx_addr", rd_addr_q[b_rd + i], (i % 2 == 1) ? 19'h40020 : 19'h00010);
            check("rr_ack_owner", ack_q[b_q + i], i % 2);
        end
        check("rr_bg_data", bus.bg_data, 8'hF0);
        check("rr_sp_data", bus.sp_data, 8'hC0);
        repeat (2) step();
        check("rr_reads", reads - b_rd, 4);
        check("rr_busy_idle", bus.busy, 0);

        // ---- Fixed priority: background starves sprite while held
        bus.prio_bg = 1'b1;
        bus.bg_addr = 19'h00333;
        bus.sp_addr = 19'h40077;
        b_bg        = bg_acks;
        b_sp        = sp_acks;
        bus.bg_req  = 1'b1;
        bus.sp_req  = 1'b1;
        n           = 0;
        while (bg_acks < b_bg + 8 && n < 120) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        step();
        bus.bg_req = 1'b0;
        check("fp_bg_acks", bg_acks - b_bg, 8);
        check("fp_sp_acks", sp_acks - b_sp, 0);
        check("fp_bg_data", bus.bg_data, 8'hD3);
        b_rd = reads;
        wait_ack(1'b1, 20, n, g);
        check("fp_sp_latency", n, 4);
        check("fp_sp_addr", rd_addr_q[b_rd], 19'h40077);
        check("fp_sp_data", bus.sp_data, 8'h97);
        step();
        bus.sp_req = 1'b0;
        step();

        // ---- Variable ROM latency, address changed while granted
        for (int i = 0; i < 3; i++) begin
            rom_lat     = lats[i];
            b_rd        = reads;
            bus.bg_req  = 1'b1;
            bus.bg_addr = addrs[i];
            step();
            bus.bg_addr = ~addrs[i];
            wait_ack(1'b0, 40, n, g);
            check("var_latency", n, lats[i] + 2);
            check("var_busy_gaps", g, 0);
            check("var_bg_data", bus.bg_data, rom_byte(addrs[i]));
            check("var_gfx_addr", bus.gfx_addr, addrs[i]);
            step();
            bus.bg_req = 1'b0;
            step();
            check("var_reads", reads - b_rd, 1);
        end
        check("var_sp_data_kept", bus.sp_data, 8'h97);

        // ---- Reset while in WAIT, late gfx_valid afterwards
        bus.prio_bg = 1'b0;
        rom_lat     = 3;
        b_rd        = reads;
        b_bg        = bg_acks;
        b_sp        = sp_acks;
        bus.bg_addr = 19'h01234;
        bus.bg_req  = 1'b1;
        step();
        step();
        reset      = 1'b1;
        bus.bg_req = 1'b0;
        step();
        reset = 1'b0;
        check("rw_post_reset_strobes", {bus.gfx_read, bus.busy}, 2'b00);
        repeat (6) step();
        check("rw_no_bg_ack", bg_acks - b_bg, 0);
        check("rw_no_sp_ack", sp_acks - b_sp, 0);
        check("rw_reads", reads - b_rd, 1);
        check("rw_busy_idle", bus.busy, 0);
        check("rw_bg_data_cleared", bus.bg_data, 8'h00);
        rom_lat     = 1;
        b_rd        = reads;
        bus.bg_req  = 1'b1;
        bus.sp_req  = 1'b1;
        wait_ack(1'b0, 20, n, g);
        check("rw_next_latency", n, 4);
        check("rw_next_addr", rd_addr_q[b_rd], 19'h01234);
        check("rw_next_bg_data", bus.bg_data, 8'hD4);
        step();
        bus.bg_req = 1'b0;
        bus.sp_req = 1'b0;
        repeat (2) step();

`ifdef GFX_FETCH_ARBITER_TIMEOUT_EN
        // ---- Timeout: ROM never answers a sprite read
        rom_mute    = 1'b1;
        bus.sp_addr = 19'h55555;
        bus.sp_req  = 1'b1;
        wait_ack(1'b1, 100, n, g);
        check("to_latency", n, 67);
        check("to_sp_data", bus.sp_data, 8'hFF);
        check("to_flag", bus.timeout_flag, 1);
        step();
        bus.sp_req = 1'b0;
        rom_mute   = 1'b0;
        repeat (3) step();
        check("to_flag_sticky", bus.timeout_flag, 1);
        check("to_busy_idle", bus.busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
